// File: rtl/mem_port_arbiter_pkg.sv
//==============================================================================
// Module   : mips_pkg
// Desc     : Shared encodings and default widths for the memory-port arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    // Identifies which requester last owned the port; drives round-robin.
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 15;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_watchdog.sv
//==============================================================================
// Module   : mem_port_watchdog
// Desc     : Counts wait cycles of an access and flags expiry at the limit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_watchdog
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic ready,
    output logic expire
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    // Expiry lands on the TIMEOUT_CYCLES-th wait cycle; a real ready wins.
    assign expire = active && !ready && (r_count == c_LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (active && !ready && !expire) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module   : mem_port_arbiter
// Desc     : Round-robin sharing of one variable-latency memory port between
//            instruction fetch and load/store. Define MEM_PORT_ARB_TIMEOUT_EN
//            to add the access watchdog (err pulse on timeout).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  err
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    arb_state_t            r_state,      w_state_nxt;
    owner_t                r_last_grant, w_last_grant_nxt;
    logic                  r_mem_en,     w_mem_en_nxt;
    logic                  r_mem_we,     w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr,   w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0] r_mem_wdata,  w_mem_wdata_nxt;
    logic [DATA_WIDTH-1:0] r_if_rdata,   w_if_rdata_nxt;
    logic [DATA_WIDTH-1:0] r_d_rdata,    w_d_rdata_nxt;
    logic                  r_if_ack,     w_if_ack_nxt;
    logic                  r_d_ack,      w_d_ack_nxt;
    logic                  r_err,        w_err_nxt;

    logic w_if_eff;
    logic w_d_eff;
    logic w_expire;
    logic w_done;

    // A requester is invisible during its own ack cycle so a held req
    // is not mistaken for a second transfer.
    assign w_if_eff = if_req & ~r_if_ack;
    assign w_d_eff  = d_req  & ~r_d_ack;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    logic w_wd_clear;
    logic w_wd_active;

    assign w_wd_clear  = (r_state == IDLE) && (w_if_eff || w_d_eff);
    assign w_wd_active = (r_state != IDLE);

    mem_port_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_wd_clear),
        .active (w_wd_active),
        .ready  (mem_ready),
        .expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    assign w_done = mem_ready | w_expire;

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_mem_en_nxt     = r_mem_en;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_if_rdata_nxt   = r_if_rdata;
        w_d_rdata_nxt    = r_d_rdata;
        w_if_ack_nxt     = 1'b0;
        w_d_ack_nxt      = 1'b0;
        w_err_nxt        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_if_eff && (!w_d_eff || r_last_grant == OWN_DATA)) begin
                    w_state_nxt      = FETCH;
                    w_last_grant_nxt = OWN_FETCH;
                    w_mem_en_nxt     = 1'b1;
                    w_mem_we_nxt     = 1'b0;
                    w_mem_addr_nxt   = if_addr;
                    w_mem_wdata_nxt  = '0;
                end else if (w_d_eff) begin
                    w_state_nxt      = DATA;
                    w_last_grant_nxt = OWN_DATA;
                    w_mem_en_nxt     = 1'b1;
                    w_mem_we_nxt     = d_we;
                    w_mem_addr_nxt   = d_addr;
                    w_mem_wdata_nxt  = d_we ? d_wdata : '0;
                end
            end
            FETCH: begin
                if (w_done) begin
                    w_state_nxt    = IDLE;
                    w_mem_en_nxt   = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_if_rdata_nxt = mem_ready ? mem_rdata : '0;
                    w_if_ack_nxt   = 1'b1;
                    w_err_nxt      = w_expire;
                end
            end
            DATA: begin
                if (w_done) begin
                    w_state_nxt   = IDLE;
                    w_mem_en_nxt  = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    // Stores report zero; only a completed load returns data.
                    w_d_rdata_nxt = (mem_ready && !r_mem_we) ? mem_rdata : '0;
                    w_d_ack_nxt   = 1'b1;
                    w_err_nxt     = w_expire;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_mem_en_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_grant <= OWN_DATA;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_d_ack      <= w_d_ack_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ack    = r_if_ack;
    assign d_rdata   = r_d_rdata;
    assign d_ack     = r_d_ack;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module   : tb_mem_port_arbiter
// Desc     : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a transaction-level memory model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          busy;
    logic          err;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        bit            is_d;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            waits;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        logic [DW-1:0] exp_wd;
        logic          exp_we;
        exp_we = v.is_d && v.we;
        exp_wd = exp_we ? v.wdata : '0;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        tick();
        chk($sformatf("v%0d_en", k), mem_en, 1);
        chk($sformatf("v%0d_addr", k), mem_addr, v.addr);
        chk($sformatf("v%0d_we", k), mem_we, exp_we);
        chk($sformatf("v%0d_wdata", k), mem_wdata, exp_wd);
        for (int w = 0; w <= v.waits; w++) begin
            mem_ready = (w == v.waits);
            mem_rdata = v.rdata;
            tick();
            if (w < v.waits) begin
                chk($sformatf("v%0d_hold_en", k), mem_en, 1);
                chk($sformatf("v%0d_hold_we", k), mem_we, exp_we);
                chk($sformatf("v%0d_early_ack", k), if_ack | d_ack, 0);
            end
        end
        chk($sformatf("v%0d_if_ack", k), if_ack, !v.is_d);
        chk($sformatf("v%0d_d_ack", k), d_ack, v.is_d);
        chk($sformatf("v%0d_rdata", k), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
        chk($sformatf("v%0d_busy", k), busy, 0);
        chk($sformatf("v%0d_en_off", k), mem_en, 0);
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0BAD_0BAD;
        tick();
        chk($sformatf("v%0d_pulse", k), if_ack | d_ack, 0);
        chk($sformatf("v%0d_rdata_hold", k), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    endtask

    task automatic run_random(input int cycles);
        logic [DW-1:0] memm [64];
        logic [AW-1:0] p_if_addr, p_d_addr, cur_addr;
        logic [DW-1:0] p_d_wdata, cur_wdata, exp_rd;
        bit p_if_req, p_d_req, p_if_ack, p_d_ack, p_en, p_ready, p_d_we;
        bit cur_we, e_if_ack, e_d_ack, e_en, cand_f, cand_d;
        int owner, lastw, wait_left;
        for (int i = 0; i < 64; i++) memm[i] = 32'hA500_0000 ^ DW'(i * 7);
        p_if_req = 0; p_d_req = 0; p_if_ack = 0; p_d_ack = 0; p_en = 0; p_ready = 0; p_d_we = 0;
        p_if_addr = '0; p_d_addr = '0; p_d_wdata = '0;
        cur_addr = '0; cur_wdata = '0; cur_we = 0; exp_rd = '0;
        owner = 0; lastw = 1; wait_left = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            e_if_ack = p_en && p_ready && owner == 0;
            e_d_ack  = p_en && p_ready && owner == 1;
            chk("rnd_if_ack", if_ack, e_if_ack);
            chk("rnd_d_ack", d_ack, e_d_ack);
            if (e_if_ack) chk("rnd_if_rdata", if_rdata, exp_rd);
            if (e_d_ack)  chk("rnd_d_rdata", d_rdata, exp_rd);
            cand_f = p_if_req && !p_if_ack;
            cand_d = p_d_req && !p_d_ack;
            if (!p_en && (cand_f || cand_d)) begin
                owner     = (cand_f && cand_d) ? 1 - lastw : (cand_d ? 1 : 0);
                lastw     = owner;
                cur_addr  = (owner == 1) ? p_d_addr : p_if_addr;
                cur_we    = (owner == 1) && p_d_we;
                cur_wdata = cur_we ? p_d_wdata : '0;
                wait_left = $urandom_range(0, 3);
                e_en      = 1;
            end else begin
                e_en = p_en && !p_ready;
            end
            chk("rnd_mem_en", mem_en, e_en);
            chk("rnd_busy", busy, e_en);
            if (e_en) begin
                chk("rnd_mem_addr", mem_addr, cur_addr);
                chk("rnd_mem_we", mem_we, cur_we);
                chk("rnd_mem_wdata", mem_wdata, cur_wdata);
            end
            mem_rdata = $urandom();
            if (e_en) begin
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    if (cur_we) begin
                        memm[cur_addr[5:0]] = cur_wdata;
                        exp_rd = '0;
                    end else begin
                        mem_rdata = memm[cur_addr[5:0]];
                        exp_rd    = mem_rdata;
                    end
                end else begin
                    mem_ready = 1'b0;
                    wait_left--;
                end
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
            end
            if (e_if_ack || !if_req) begin
                if_req  = ($urandom_range(0, 1) == 1);
                if_addr = AW'($urandom_range(0, 63));
            end
            if (e_d_ack || !d_req) begin
                d_req   = ($urandom_range(0, 1) == 1);
                d_we    = ($urandom_range(0, 1) == 1);
                d_addr  = AW'($urandom_range(0, 63));
                d_wdata = $urandom();
            end
            p_if_req = if_req; p_if_addr = if_addr; p_if_ack = e_if_ack;
            p_d_req = d_req; p_d_we = d_we; p_d_addr = d_addr; p_d_wdata = d_wdata;
            p_d_ack = e_d_ack; p_en = e_en; p_ready = mem_ready;
        end
    endtask

    vec_t vecs [6];
    int   n;
    int   bad;
    bit   pen;

    initial begin
        vecs[0] = '{is_d: 0, we: 0, addr: 32'h10,       wdata: 32'h0,        rdata: 32'h2008_0005, waits: 0, exp_rdata: 32'h2008_0005};
        vecs[1] = '{is_d: 1, we: 1, addr: 32'h40,       wdata: 32'hDEAD_BEEF, rdata: 32'h1234_5678, waits: 3, exp_rdata: 32'h0};
        vecs[2] = '{is_d: 1, we: 0, addr: 32'h44,       wdata: 32'h5555_5555, rdata: 32'hCAFE_F00D, waits: 1, exp_rdata: 32'hCAFE_F00D};
        vecs[3] = '{is_d: 0, we: 0, addr: 32'h11,       wdata: 32'h0,        rdata: 32'h8C22_0004, waits: 2, exp_rdata: 32'h8C22_0004};
        vecs[4] = '{is_d: 1, we: 1, addr: 32'h7FFF_FFFF, wdata: 32'hFFFF_FFFF, rdata: 32'h7777_7777, waits: 0, exp_rdata: 32'h0};
        vecs[5] = '{is_d: 1, we: 0, addr: 32'hFFFF_FFFF, wdata: 32'h0,        rdata: 32'hA5A5_A5A5, waits: 0, exp_rdata: 32'hA5A5_A5A5};

        // reset state
        #2;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acks", {if_ack, d_ack}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        do_reset();

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_ready_busy", busy | mem_en, 0);
            chk("idle_ready_ack", if_ack | d_ack, 0);
        end
        mem_ready = 1'b0;

        // collision after reset: fetch first, data in fetch's ack cycle
        do_reset();
        if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
        tick();
        chk("col1_addr", mem_addr, 32'h100);
        mem_ready = 1; mem_rdata = 32'h1111_0000;
        tick();
        chk("col1_if_ack", if_ack, 1);
        if_req = 0; mem_ready = 0;
        tick();
        chk("col2_en", mem_en, 1);
        chk("col2_addr", mem_addr, 32'h200);
        mem_ready = 1; mem_rdata = 32'h2222_0000;
        tick();
        chk("col2_d_ack", d_ack, 1);
        chk("col2_d_rdata", d_rdata, 32'h2222_0000);
        d_req = 0; mem_ready = 0;
        tick();
        if_req = 1; if_addr = 32'h104; d_req = 1; d_addr = 32'h204;
        tick();
        chk("col3_addr", mem_addr, 32'h104);

        // both requesting continuously: strict alternation
        do_reset();
        if_req = 1; if_addr = 32'h1000_0000; d_req = 1; d_we = 0; d_addr = 32'h2000_0000;
        n = 0; pen = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick();
            chk("alt_ack_overlap", if_ack & d_ack, 0);
            if (mem_en && !pen) begin
                chk($sformatf("alt_grant%0d", n), mem_addr[31:28], (n % 2 == 0) ? 1 : 2);
                n++;
            end
            if (if_ack) if_addr = if_addr + 1;
            if (d_ack)  d_addr = d_addr + 1;
            mem_ready = mem_en;
            pen = mem_en;
        end
        chk("alt_count", n, 6);

        // reset while a store waits on memory
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h55; d_wdata = 32'h1234_5678;
        tick();
        tick();
        chk("rmid_pre_we", mem_we, 1);
        #2 reset = 1'b0;
        #1;
        chk("rmid_en", mem_en, 0);
        chk("rmid_we", mem_we, 0);
        chk("rmid_addr", mem_addr, 0);
        chk("rmid_wdata", mem_wdata, 0);
        chk("rmid_busy", busy, 0);
        d_req = 0;
        tick();
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (d_ack || busy) bad++;
        end
        chk("rmid_no_dack", bad, 0);
        run_vec(vecs[0], 10);

        // memory that never answers
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h80; mem_ready = 0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        bad = 0;
        for (int c = 0; c < TO; c++) begin
            tick();
            if (!busy || d_ack || err) bad++;
        end
        chk("to_wait", bad, 0);
        tick();
        chk("to_ack", d_ack, 1);
        chk("to_err", err, 1);
        chk("to_rdata", d_rdata, 0);
        chk("to_busy", busy, 0);
        d_req = 0;
        tick();
        chk("to_err_pulse", err, 0);
`else
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (!busy || d_ack || err) bad++;
        end
        chk("nowd_wait_forever", bad, 0);
`endif

        do_reset();
        run_random(600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
